store_buffer: RTL and testbench

// Sits between the execute/memory pipeline stage and data_memory. Accepts stores into
// a small in-order FIFO and drains them to data_memory one per cycle when the port is free.

---
 rtl/store_buffer.sv | 113 +++++++++++
 tb/tb_store_buffer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Small in-order store FIFO between the pipeline and data_memory. Loads take
// the memory port first and are forwarded from the youngest matching store.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          st_valid,
    input  logic [AW-1:0] st_addr,
    input  logic [DW-1:0] st_data,
    output logic          st_ready,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    output logic [DW-1:0] ld_data,
    output logic          ld_hit,
    input  logic          flush,
    output logic          empty,
    output logic          mem_write,
    output logic          mem_read,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    input  logic [DW-1:0] mem_out
);
    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_reg [DEPTH];
    logic [DW-1:0] data_reg [DEPTH];
    logic [PW-1:0] head_reg, head_next;
    logic [PW-1:0] tail_reg, tail_next;
    logic [PW:0]   count_reg, count_next;

    logic          buf_empty, buf_full;
    logic          push, drain, load_go;
    logic [DEPTH-1:0] match;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign buf_empty = (count_reg == '0);
    assign buf_full  = (count_reg == (PW+1)'(DEPTH));

    // An entry is live when its distance from head is below count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PW-1:0] age;
            assign age       = PW'(gi) - head_reg;
            assign match[gi] = ({1'b0, age} < count_reg) && (addr_reg[gi] == ld_addr);
        end
    endgenerate

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (match[head_reg + PW'(k)]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_reg[head_reg + PW'(k)];
            end
        end
    end

    // Reset gates every port-facing action, so the reset cycle itself is quiet.
    always_comb begin
        push    = !reset && st_valid && !buf_full;
        drain   = !reset && !buf_empty && (flush || !ld_valid);
        load_go = !reset && ld_valid && !(flush && !buf_empty);

        mem_write = drain;
        mem_read  = load_go;
        mem_addr  = '0;
        mem_in    = '0;
        if (drain) begin
            mem_addr = addr_reg[head_reg];
            mem_in   = data_reg[head_reg];
        end else if (load_go) begin
            mem_addr = ld_addr;
        end

        ld_hit   = !reset && ld_valid && fwd_hit;
        ld_data  = ld_hit ? fwd_data : mem_out;
        st_ready = reset || !buf_full;
        empty    = reset || buf_empty;
    end

    always_comb begin
        head_next  = head_reg + PW'(drain);
        tail_next  = tail_reg + PW'(push);
        count_next = count_reg + (PW+1)'(push) - (PW+1)'(drain);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Entry storage needs no reset: liveness comes from head/count.
    always_ff @(posedge clock) begin
        if (push) begin
            addr_reg[tail_reg] <= st_addr;
            data_reg[tail_reg] <= st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a small behavioural data_memory and
// hand-computed expectations for each scenario.
module tb_store_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [31:0] st_addr, st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr, ld_data;
    logic        ld_hit;
    logic        flush;
    logic        empty;
    logic        mem_write, mem_read;
    logic [31:0] mem_addr, mem_in, mem_out;

    logic [31:0] mem [0:255];
    integer tests = 0;
    integer fails = 0;

    always #5 clk = ~clk;

    assign mem_out = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[7:0]] <= mem_in;
            $display("[TB] write addr=%0d data=%0d", mem_addr, mem_in);
        end
        if (mem_read)
            $display("[TB] read  addr=%0d ld_data=%0d hit=%0b", mem_addr, ld_data, ld_hit);
    end

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clock(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
        .flush(flush), .empty(empty),
        .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
        .mem_in(mem_in), .mem_out(mem_out)
    );

    // Applies one cycle of inputs just after the falling edge and lets them settle.
    task automatic drive(input logic rs, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lv, input logic [31:0] la, input logic fl);
        @(negedge clk);
        reset = rs; st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la; flush = fl;
        #1;
    endtask

    task automatic test_reset;
        drive(1, 0, 0, 0, 1, 20, 0);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL rst_st_ready got=%0b exp=1", st_ready); end
        tests++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL rst_mem_rw got=%0b%0b exp=00", mem_read, mem_write); end
        tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL rst_mem_addr got=%0d exp=0", mem_addr); end
        drive(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_single;
        drive(0, 1, 10, 500, 0, 0, 0);
        tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL t1_latency got=%0b exp=0", mem_write); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (mem_write !== 1'b1 || mem_addr !== 32'd10 || mem_in !== 32'd500) begin
            fails++; $display("FAIL t1_drain got=%0b/%0d/%0d exp=1/10/500", mem_write, mem_addr, mem_in); end
        drive(0, 0, 0, 0, 1, 10, 0);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL t1_empty got=%0b exp=1", empty); end
        tests++; if (ld_data !== 32'd500 || ld_hit !== 1'b0 || mem_read !== 1'b1) begin
            fails++; $display("FAIL t1_load got=%0d/%0b/%0b exp=500/0/1", ld_data, ld_hit, mem_read); end
    endtask

    task automatic test_forward;
        drive(0, 1, 10, 500, 1, 99, 0);
        drive(0, 1, 10, 600, 1, 99, 0);
        drive(0, 0, 0, 0, 1, 10, 0);
        tests++; if (ld_hit !== 1'b1 || ld_data !== 32'd600) begin
            fails++; $display("FAIL t2_fwd got=%0b/%0d exp=1/600", ld_hit, ld_data); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (mem_write !== 1'b1 || mem_in !== 32'd500) begin fails++; $display("FAIL t2_drain0 got=%0b/%0d exp=1/500", mem_write, mem_in); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (mem_write !== 1'b1 || mem_in !== 32'd600) begin fails++; $display("FAIL t2_drain1 got=%0b/%0d exp=1/600", mem_write, mem_in); end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (mem[10] !== 32'd600 || empty !== 1'b1) begin fails++; $display("FAIL t2_mem got=%0d/%0b exp=600/1", mem[10], empty); end
    endtask

    task automatic test_full;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 30 + i, 1 + i, 1, 99, 0);
            tests++; if (st_ready !== 1'b1) begin fails++; $display("FAIL t3_ready%0d got=%0b exp=1", i, st_ready); end
        end
        drive(0, 1, 34, 5, 1, 99, 0);
        tests++; if (st_ready !== 1'b0 || mem_write !== 1'b0) begin fails++; $display("FAIL t3_full got=%0b/%0b exp=0/0", st_ready, mem_write); end
        tests++; if (ld_data !== 32'hdeadbeef || ld_hit !== 1'b0) begin fails++; $display("FAIL t3_ld99 got=%h/%0b exp=deadbeef/0", ld_data, ld_hit); end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tests++; if (mem_write !== 1'b1 || mem_addr !== 32'(30 + i) || mem_in !== 32'(1 + i)) begin
                fails++; $display("FAIL t3_order%0d got=%0b/%0d/%0d exp=1/%0d/%0d", i, mem_write, mem_addr, mem_in, 30 + i, 1 + i); end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (empty !== 1'b1 || mem_write !== 1'b0 || mem[34] !== 32'd0) begin
            fails++; $display("FAIL t3_dropped got=%0b/%0b/%0d exp=1/0/0", empty, mem_write, mem[34]); end
    endtask

    task automatic test_load_priority;
        drive(0, 1, 40, 7, 1, 99, 0);
        drive(0, 1, 41, 8, 1, 99, 0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 1, 20, 0);
            tests++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'd20) begin
                fails++; $display("FAIL t4_port%0d got=%0b/%0b/%0d exp=1/0/20", i, mem_read, mem_write, mem_addr); end
            tests++; if (ld_data !== 32'd1234 || ld_hit !== 1'b0) begin
                fails++; $display("FAIL t4_data%0d got=%0d/%0b exp=1234/0", i, ld_data, ld_hit); end
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tests++; if (mem_write !== 1'b1 || mem_addr !== 32'(40 + i) || mem_in !== 32'(7 + i)) begin
                fails++; $display("FAIL t4_drain%0d got=%0b/%0d/%0d exp=1/%0d/%0d", i, mem_write, mem_addr, mem_in, 40 + i, 7 + i); end
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 4; i++) drive(0, 1, 50 + i, 11 + i, 1, 99, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 52, 1);
            tests++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'(50 + i) || mem_in !== 32'(11 + i)) begin
                fails++; $display("FAIL t5_flush%0d got=%0b/%0b/%0d/%0d exp=1/0/%0d/%0d", i, mem_write, mem_read, mem_addr, mem_in, 50 + i, 11 + i); end
            tests++; if (ld_hit !== (i <= 2) || (i <= 2 && ld_data !== 32'd13)) begin
                fails++; $display("FAIL t5_fwd%0d got=%0b/%0d exp=%0b/13", i, ld_hit, ld_data, i <= 2); end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (empty !== 1'b1 || mem[52] !== 32'd13) begin fails++; $display("FAIL t5_empty got=%0b/%0d exp=1/13", empty, mem[52]); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(0, 1, 60 + i, 21 + i, 0, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            if (i == 0) begin
                tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL b2b_first got=%0b exp=0", mem_write); end
            end else begin
                tests++; if (mem_write !== 1'b1 || mem_addr !== 32'(59 + i) || mem_in !== 32'(20 + i) || st_ready !== 1'b1) begin
                    fails++; $display("FAIL b2b_drain%0d got=%0b/%0d/%0d exp=1/%0d/%0d", i, mem_write, mem_addr, mem_in, 59 + i, 20 + i); end
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got=%0b exp=1", empty); end
    endtask

    task automatic test_reset_mid_drain;
        for (int i = 0; i < 3; i++) drive(0, 1, 70 + i, 31 + i, 1, 99, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++; if (mem_write !== 1'b1 || mem_addr !== 32'd70) begin fails++; $display("FAIL t6_drain got=%0b/%0d exp=1/70", mem_write, mem_addr); end
        drive(1, 0, 0, 0, 1, 71, 0);
        tests++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 32'd0 || mem_in !== 32'd0) begin
            fails++; $display("FAIL t6_rst_port got=%0b/%0b/%0d/%0d exp=0/0/0/0", mem_write, mem_read, mem_addr, mem_in); end
        tests++; if (ld_hit !== 1'b0 || empty !== 1'b1 || st_ready !== 1'b1) begin
            fails++; $display("FAIL t6_rst_flags got=%0b/%0b/%0b exp=0/1/1", ld_hit, empty, st_ready); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            tests++; if (mem_write !== 1'b0 || empty !== 1'b1) begin fails++; $display("FAIL t6_after%0d got=%0b/%0b exp=0/1", i, mem_write, empty); end
        end
        tests++; if (mem[70] !== 32'd31 || mem[71] !== 32'd0 || mem[72] !== 32'd0) begin
            fails++; $display("FAIL t6_mem got=%0d/%0d/%0d exp=31/0/0", mem[70], mem[71], mem[72]); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[99] = 32'hdeadbeef;
        mem[20] = 32'd1234;
        reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_valid = 1'b0; ld_addr = '0; flush = 1'b0;
        test_reset;
        test_single;
        test_forward;
        test_full;
        test_load_priority;
        test_flush;
        test_back_to_back;
        test_reset_mid_drain;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
